adder_tree_acc: RTL

Parametrised, pipelined, flow-controlled reduction tree with a multi-beat accumulator. It sums NUM_IN signed values per beat through a registered radix-4 tree, then accumulates successive beats between first/last markers into one wide result. It is the next-generation replacement for the fixed 64-input adder trees in the binary neural-net datapath, where it accumulates XNOR-popcount partial sums across input-channel tiles before thresholding.

---
 rtl/adder_tree_pkg.sv | 43 ++++
 rtl/adder_tree_level.sv | 64 ++++++
 rtl/adder_tree_acc.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/adder_tree_pkg.sv
// Shared constants, types and elaboration helpers for the adder tree accumulator.
// No logic; only compile-time helpers.
// Not applicable (no handshake).
package adder_tree_pkg;

   localparam int FANIN = 4;

   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } acc_state_t;

   // ceil(log4(n)): number of registered radix-4 levels needed for n lanes
   function automatic int num_levels(input int n);
      int s;
      int c;
      s = 0;
      c = 1;
      for (int j = 0; j < 16; j++) begin
         if (c < n) begin
            c = c * FANIN;
            s = s + 1;
         end
      end
      return s;
   endfunction

   // Lane count after zero padding to a full radix-4 tree
   function automatic int pad_lanes(input int n);
      return 1 << (2 * num_levels(n));
   endfunction

   // Lane index where level k's inputs start in the flattened lane vector
   function automatic int lane_offset(input int p, input int k);
      int off;
      off = 0;
      for (int j = 0; j < 16; j++) begin
         if (j < k) off = off + (p >> (2 * j));
      end
      return off;
   endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered radix-4 reduction level carrying valid/first/last alongside the sums.
// Latency: 1 cycle.
// Backpressure: every register holds while adv is low.
module adder_tree_level
   import adder_tree_pkg::*;
#(
   parameter int LANES_IN = 4,
   parameter int W        = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               adv,
   input  logic [LANES_IN-1:0][W-1:0]         lanes_i,
   input  logic                               vld_i,
   input  logic                               first_i,
   input  logic                               last_i,
   output logic [LANES_IN/FANIN-1:0][W-1:0]   lanes_o,
   output logic                               vld_o,
   output logic                               first_o,
   output logic                               last_o
);

   localparam int LANES_OUT = LANES_IN / FANIN;

   logic [LANES_OUT-1:0][W-1:0] sum_d;
   logic [LANES_OUT-1:0][W-1:0] sum_q;
   logic                        vld_q;
   logic                        first_q;
   logic                        last_q;

   // Sum each group of four adjacent lanes; wraps modulo 2^W like the accumulator
   always_comb begin
      sum_d = '0;
      for (int j = 0; j < LANES_OUT; j++) begin
         for (int k = 0; k < FANIN; k++) begin
            sum_d[j] = sum_d[j] + lanes_i[j*FANIN + k];
         end
      end
   end

   // Sideband bits: only valid needs a defined reset value, first/last follow it
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q   <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
      end else if (adv) begin
         vld_q   <= vld_i;
         first_q <= first_i;
         last_q  <= last_i;
      end
   end

   // Data register is qualified by vld_q downstream, so it needs no reset
   always_ff @(posedge clk) begin
      if (adv) sum_q <= sum_d;
   end

   assign lanes_o = sum_q;
   assign vld_o   = vld_q;
   assign first_o = first_q;
   assign last_o  = last_q;

endmodule

// File: rtl/adder_tree_acc.sv
// Pipelined radix-4 reduction of NUM_IN signed inputs plus a first/last multi-beat accumulator.
// Latency: S+1 cycles from last-beat acceptance to out_valid (S = ceil(log4(NUM_IN))).
// Backpressure: one global advance; out_valid & ~out_ready freezes the whole pipe and drops in_ready.
module adder_tree_acc
   import adder_tree_pkg::*;
#(
   parameter int NUM_IN    = 64,
   parameter int WIDTH_IN  = 8,
   parameter int MAX_BEATS = 256,
   parameter int W_OUT     = WIDTH_IN + $clog2(NUM_IN) + $clog2(MAX_BEATS)
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic signed [NUM_IN-1:0][WIDTH_IN-1:0]   in_data,
   input  logic                                     in_valid,
   input  logic                                     in_first,
   input  logic                                     in_last,
   output logic                                     in_ready,
   output logic signed [W_OUT-1:0]                  out_sum,
   output logic [$clog2(MAX_BEATS):0]               out_beats,
   output logic                                     out_ovf,
   output logic                                     out_valid,
   input  logic                                     out_ready
);

   localparam int S  = num_levels(NUM_IN);
   localparam int P  = pad_lanes(NUM_IN);
   localparam int T  = lane_offset(P, S) + 1;
   localparam int BW = $clog2(MAX_BEATS) + 1;
   localparam logic [BW-1:0] MAX_B = BW'(MAX_BEATS);

   // All tree levels share one flattened lane vector: level k reads its slice, writes the next
   logic [T-1:0][W_OUT-1:0] tree_lanes;
   logic [S:0]              t_vld;
   logic [S:0]              t_first;
   logic [S:0]              t_last;
   logic                    adv;

   acc_state_t        state_q;
   logic [W_OUT-1:0]  acc_q, acc_d;
   logic [BW-1:0]     beats_q, beats_d;
   logic              ovf_q, ovf_d;
   logic              restart;
   logic              out_valid_q;
   logic [W_OUT-1:0]  out_sum_q;
   logic [BW-1:0]     out_beats_q;
   logic              out_ovf_q;

   logic              tree_vld, tree_first, tree_last;
   logic [W_OUT-1:0]  tree_sum;

   assign adv      = ~out_valid_q | out_ready;
   assign in_ready = adv & ~rst;

   assign t_vld[0]   = in_valid & in_ready;
   assign t_first[0] = in_valid & in_first;
   assign t_last[0]  = in_valid & in_last;

   // Sign-extend real inputs to the result width; padding lanes contribute zero
   for (genvar i = 0; i < P; i++) begin : g_ext
      if (i < NUM_IN) begin : g_in
         assign tree_lanes[i] = {{(W_OUT-WIDTH_IN){in_data[i][WIDTH_IN-1]}}, in_data[i]};
      end else begin : g_pad
         assign tree_lanes[i] = '0;
      end
   end

   for (genvar k = 0; k < S; k++) begin : g_lvl
      localparam int LIN  = P >> (2*k);
      localparam int OIN  = lane_offset(P, k);
      localparam int OOUT = lane_offset(P, k+1);
      adder_tree_level #(
         .LANES_IN (LIN),
         .W        (W_OUT)
      ) u_level (
         .clk      (clk),
         .rst      (rst),
         .adv      (adv),
         .lanes_i  (tree_lanes[OIN +: LIN]),
         .vld_i    (t_vld[k]),
         .first_i  (t_first[k]),
         .last_i   (t_last[k]),
         .lanes_o  (tree_lanes[OOUT +: LIN/FANIN]),
         .vld_o    (t_vld[k+1]),
         .first_o  (t_first[k+1]),
         .last_o   (t_last[k+1])
      );
   end

   assign tree_vld   = t_vld[S];
   assign tree_first = t_first[S];
   assign tree_last  = t_last[S];
   assign tree_sum   = tree_lanes[T-1];

   // Next group totals for the beat leaving the tree; a missing or repeated first flags ovf
   always_comb begin
      restart = (state_q == IDLE) | tree_first;
      acc_d   = restart ? tree_sum : acc_q + tree_sum;
      if (restart)               beats_d = BW'(1);
      else if (beats_q == MAX_B) beats_d = MAX_B;
      else                       beats_d = beats_q + BW'(1);
      if (state_q == IDLE) ovf_d = ~tree_first;
      else                 ovf_d = tree_first | ovf_q | (beats_q == MAX_B);
   end

   // Accumulator FSM and result register; a new result overrides a same-cycle handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         beats_q     <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_beats_q <= '0;
         out_ovf_q   <= 1'b0;
      end else if (adv) begin
         out_valid_q <= tree_vld & tree_last;
         if (tree_vld) begin
            acc_q   <= acc_d;
            beats_q <= beats_d;
            if (tree_last) begin
               out_sum_q   <= acc_d;
               out_beats_q <= beats_d;
               out_ovf_q   <= ovf_d;
               ovf_q       <= 1'b0;
               state_q     <= IDLE;
            end else begin
               ovf_q   <= ovf_d;
               state_q <= ACC;
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_beats = out_beats_q;
   assign out_ovf   = out_ovf_q;

endmodule
